// File: rtl/tw_cmd_sequencer_pkg.sv
// Shared definitions for the three-wire blocks.
// Contents: sequencer FSM state encodings, r_w encodings, counter sizing helper.
package tw_cmd_sequencer_pkg;

  localparam int unsigned TW_ST_W = 3;

  // Sequencer FSM states
  localparam logic [TW_ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [TW_ST_W-1:0] ST_LAUNCH    = 3'd1;
  localparam logic [TW_ST_W-1:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [TW_ST_W-1:0] ST_WAIT_DONE = 3'd3;
  localparam logic [TW_ST_W-1:0] ST_RESPOND   = 3'd4;

  // Three-wire transfer direction
  localparam logic TW_RW_READ  = 1'b0;
  localparam logic TW_RW_WRITE = 1'b1;

  // Bits needed to count 0..max_val (at least one bit)
  function automatic int unsigned tw_cnt_bits(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tw_cmd_fifo.sv
// Command queue for the three-wire sequencer: synchronous FIFO with show-ahead
// head output and an occupancy count.
// Ports: in_clk/in_rst (async, active-high); i_push/i_data write side;
// i_pop read side; o_data head entry; o_full/o_empty flags; o_level count.
module tw_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 26
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_data,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_level
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // Storage: contents are don't-care until written, so no reset
  always_ff @(posedge in_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/tw_cmd_sequencer.sv
// Queues host read/write commands and plays them one at a time into a
// three-wire master, returning one response (data + timeout flag) per command.
// Ports: in_clk/in_rst (async, active-high); in_cmd_* / out_cmd_ready host
// command channel; out_rsp_* / in_rsp_ready response channel; out_tw_* and
// in_tw_* master handshake; out_fifo_level queue occupancy; out_idle.
module tw_cmd_sequencer
  import tw_cmd_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = 9,
  parameter int unsigned DATA_BITS      = 16,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                         in_clk,
  input  logic                         in_rst,
  input  logic                         in_cmd_valid,
  output logic                         out_cmd_ready,
  input  logic                         in_cmd_r_w,
  input  logic [ADDR_BITS-1:0]         in_cmd_addr,
  input  logic [DATA_BITS-1:0]         in_cmd_wr_data,
  output logic                         out_rsp_valid,
  input  logic                         in_rsp_ready,
  output logic [DATA_BITS-1:0]         out_rsp_data,
  output logic                         out_rsp_timeout,
  output logic                         out_tw_start,
  output logic                         out_tw_r_w,
  output logic [ADDR_BITS-1:0]         out_tw_addr,
  output logic [DATA_BITS-1:0]         out_tw_wr_data,
  input  logic                         in_tw_busy,
  input  logic [DATA_BITS-1:0]         in_tw_rd_data,
  output logic [$clog2(FIFO_DEPTH):0]  out_fifo_level,
  output logic                         out_idle
);

  localparam int unsigned ENTRY_W = 1 + ADDR_BITS + DATA_BITS;
  localparam int unsigned CNT_W   = tw_cnt_bits(TIMEOUT_CYCLES);
  // Last counter value of a wait phase: TIMEOUT_CYCLES cycles are allowed
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TW_ST_W-1:0]   r_state,       w_state_nxt;
  logic                 r_tw_start,    w_tw_start_nxt;
  logic                 r_tw_r_w,      w_tw_r_w_nxt;
  logic [ADDR_BITS-1:0] r_tw_addr,     w_tw_addr_nxt;
  logic [DATA_BITS-1:0] r_tw_wr_data,  w_tw_wr_data_nxt;
  logic                 r_rsp_valid,   w_rsp_valid_nxt;
  logic [DATA_BITS-1:0] r_rsp_data,    w_rsp_data_nxt;
  logic                 r_rsp_timeout, w_rsp_timeout_nxt;
  logic [CNT_W-1:0]     r_cnt,         w_cnt_nxt;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_expired;
  logic [ENTRY_W-1:0]   w_head;

  assign w_push    = in_cmd_valid & ~w_full;
  assign w_pop     = (r_state == ST_IDLE) & ~w_empty;
  assign w_expired = (r_cnt == CNT_LAST);

  tw_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .in_clk  (in_clk),
    .in_rst  (in_rst),
    .i_push  (w_push),
    .i_data  ({in_cmd_r_w, in_cmd_addr, in_cmd_wr_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (out_fifo_level)
  );

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_tw_start_nxt    = r_tw_start;
    w_tw_r_w_nxt      = r_tw_r_w;
    w_tw_addr_nxt     = r_tw_addr;
    w_tw_wr_data_nxt  = r_tw_wr_data;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_data_nxt    = r_rsp_data;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_cnt_nxt         = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_tw_r_w_nxt     = w_head[ENTRY_W-1];
          w_tw_addr_nxt    = w_head[DATA_BITS +: ADDR_BITS];
          w_tw_wr_data_nxt = w_head[DATA_BITS-1:0];
          w_state_nxt      = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        w_tw_start_nxt = 1'b1;
        w_cnt_nxt      = '0;
        w_state_nxt    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // Start is a level: the master only samples it on its slow clock
        if (in_tw_busy) begin
          w_tw_start_nxt = 1'b0;
          w_cnt_nxt      = '0;
          w_state_nxt    = ST_WAIT_DONE;
        end else if (w_expired) begin
          w_tw_start_nxt    = 1'b0;
          w_rsp_data_nxt    = '0;
          w_rsp_timeout_nxt = 1'b1;
          w_rsp_valid_nxt   = 1'b1;
          w_state_nxt       = ST_RESPOND;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!in_tw_busy) begin
          w_rsp_data_nxt    = (r_tw_r_w == TW_RW_READ) ? in_tw_rd_data : '0;
          w_rsp_timeout_nxt = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_state_nxt       = ST_RESPOND;
        end else if (w_expired) begin
          w_rsp_data_nxt    = '0;
          w_rsp_timeout_nxt = 1'b1;
          w_rsp_valid_nxt   = 1'b1;
          w_state_nxt       = ST_RESPOND;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RESPOND: begin
        if (in_rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_tw_start_nxt  = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight command
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state       <= ST_IDLE;
      r_tw_start    <= 1'b0;
      r_tw_r_w      <= 1'b0;
      r_tw_addr     <= '0;
      r_tw_wr_data  <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_tw_start    <= w_tw_start_nxt;
      r_tw_r_w      <= w_tw_r_w_nxt;
      r_tw_addr     <= w_tw_addr_nxt;
      r_tw_wr_data  <= w_tw_wr_data_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_data    <= w_rsp_data_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  assign out_cmd_ready   = ~w_full;
  assign out_idle        = w_empty & (r_state == ST_IDLE);
  assign out_tw_start    = r_tw_start;
  assign out_tw_r_w      = r_tw_r_w;
  assign out_tw_addr     = r_tw_addr;
  assign out_tw_wr_data  = r_tw_wr_data;
  assign out_rsp_valid   = r_rsp_valid;
  assign out_rsp_data    = r_rsp_data;
  assign out_rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_tw_cmd_sequencer.sv
// Bench for tw_cmd_sequencer: table-driven commands plus directed sequences,
// a three-wire master stub, and a response scoreboard.
module tb_tw_cmd_sequencer;
  import tw_cmd_sequencer_pkg::*;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 16;
  localparam int unsigned FD = 4;
  localparam int unsigned TO = 64;

  logic          in_clk;
  logic          in_rst;
  logic          in_cmd_valid;
  logic          out_cmd_ready;
  logic          in_cmd_r_w;
  logic [AW-1:0] in_cmd_addr;
  logic [DW-1:0] in_cmd_wr_data;
  logic          out_rsp_valid;
  logic          in_rsp_ready;
  logic [DW-1:0] out_rsp_data;
  logic          out_rsp_timeout;
  logic          out_tw_start;
  logic          out_tw_r_w;
  logic [AW-1:0] out_tw_addr;
  logic [DW-1:0] out_tw_wr_data;
  logic          in_tw_busy;
  logic [DW-1:0] in_tw_rd_data;
  logic [2:0]    out_fifo_level;
  logic          out_idle;

  tw_cmd_sequencer #(
    .ADDR_BITS(AW), .DATA_BITS(DW), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_cmd_valid(in_cmd_valid), .out_cmd_ready(out_cmd_ready),
    .in_cmd_r_w(in_cmd_r_w), .in_cmd_addr(in_cmd_addr), .in_cmd_wr_data(in_cmd_wr_data),
    .out_rsp_valid(out_rsp_valid), .in_rsp_ready(in_rsp_ready),
    .out_rsp_data(out_rsp_data), .out_rsp_timeout(out_rsp_timeout),
    .out_tw_start(out_tw_start), .out_tw_r_w(out_tw_r_w), .out_tw_addr(out_tw_addr),
    .out_tw_wr_data(out_tw_wr_data), .in_tw_busy(in_tw_busy), .in_tw_rd_data(in_tw_rd_data),
    .out_fifo_level(out_fifo_level), .out_idle(out_idle)
  );

  typedef struct packed { logic rw; logic [AW-1:0] addr; logic [DW-1:0] data; } tw_exp_t;
  typedef struct packed { logic [DW-1:0] data; logic to; } rsp_exp_t;
  typedef struct {
    logic rw; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] exp_data; logic exp_to;
  } vec_t;

  tw_exp_t  q_tw[$];
  rsp_exp_t q_rsp[$];

  int checks = 0;
  int errors = 0;
  int n_rsp  = 0;

  // Master stub controls
  int   m_delay    = 5;
  int   m_busy_len = 40;
  logic m_never    = 1'b0;
  logic m_abort    = 1'b0;

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return (a == 9'h1A5) ? 16'hBEEF : {lo, ~lo};
  endfunction

  // Move to the input-drive phase just after a rising edge
  task automatic align();
    @(posedge in_clk);
    #1;
  endtask

  // Caller must be in the drive phase; returns in the drive phase after the enqueue edge
  task automatic send(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic exp_tw, input logic [DW-1:0] exp_data, input logic exp_to);
    int n;
    in_cmd_valid   = 1'b1;
    in_cmd_r_w     = rw;
    in_cmd_addr    = a;
    in_cmd_wr_data = d;
    n = 0;
    @(negedge in_clk);
    while (!out_cmd_ready && n < 500) begin
      @(negedge in_clk);
      n++;
    end
    if (!out_cmd_ready) check("cmd_accept", 32'(out_cmd_ready), 32'(1));
    else begin
      if (exp_tw) q_tw.push_back('{rw, a, d});
      q_rsp.push_back('{exp_data, exp_to});
    end
    @(posedge in_clk);
    #1;
    in_cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc && q_rsp.size() != 0; i++) @(negedge in_clk);
    check(name, 32'(q_rsp.size()), 32'(0));
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_level"},   32'(out_fifo_level),  32'(0));
    check({p, "_ready"},   32'(out_cmd_ready),   32'(1));
    check({p, "_idle"},    32'(out_idle),        32'(1));
    check({p, "_start"},   32'(out_tw_start),    32'(0));
    check({p, "_valid"},   32'(out_rsp_valid),   32'(0));
    check({p, "_timeout"}, 32'(out_rsp_timeout), 32'(0));
    check({p, "_rdata"},   32'(out_rsp_data),    32'(0));
    check({p, "_tw_rw"},   32'(out_tw_r_w),      32'(0));
    check({p, "_tw_addr"}, 32'(out_tw_addr),     32'(0));
    check({p, "_tw_wdat"}, 32'(out_tw_wr_data),  32'(0));
  endtask

  // Three-wire master stub: checks the request, holds busy, returns read data
  initial begin : master
    tw_exp_t    e;
    logic [AW-1:0] a;
    logic       held;
    in_tw_busy    = 1'b0;
    in_tw_rd_data = '0;
    forever begin
      @(negedge in_clk);
      if (!in_rst && out_tw_start && !m_never) begin
        a = out_tw_addr;
        if (q_tw.size() == 0) check("tw_unexpected", 32'(1), 32'(0));
        else begin
          e = q_tw.pop_front();
          check("tw_r_w",  32'(out_tw_r_w),     32'(e.rw));
          check("tw_addr", 32'(out_tw_addr),    32'(e.addr));
          check("tw_wdat", 32'(out_tw_wr_data), 32'(e.data));
        end
        held = 1'b1;
        for (int i = 0; i < m_delay && !m_abort; i++) begin
          @(negedge in_clk);
          if (!out_tw_start) held = 1'b0;
        end
        check("start_held", 32'(held), 32'(1));
        in_tw_busy = 1'b1;
        @(negedge in_clk);
        if (!m_abort) check("start_release", 32'(out_tw_start), 32'(0));
        for (int i = 0; i < m_busy_len && !m_abort; i++) @(negedge in_clk);
        in_tw_rd_data = model_rd(a);
        in_tw_busy    = 1'b0;
      end
    end
  end

  // Response scoreboard: compare on every accepted response
  always @(negedge in_clk) begin
    rsp_exp_t r;
    if (!in_rst && out_rsp_valid && in_rsp_ready) begin
      n_rsp++;
      if (q_rsp.size() == 0) check("rsp_unexpected", 32'(1), 32'(0));
      else begin
        r = q_rsp.pop_front();
        check("rsp_data",    32'(out_rsp_data),    32'(r.data));
        check("rsp_timeout", 32'(out_rsp_timeout), 32'(r.to));
      end
    end
  end

  initial begin : main
    vec_t vecs [5];
    int   n;
    int   cnt;
    int   n_save;
    logic ok;

    vecs[0] = '{TW_RW_READ,  9'h1A5, 16'h0000, 16'hBEEF, 1'b0};
    vecs[1] = '{TW_RW_WRITE, 9'h003, 16'h1234, 16'h0000, 1'b0};
    vecs[2] = '{TW_RW_READ,  9'h042, 16'hFFFF, 16'h42BD, 1'b0};
    vecs[3] = '{TW_RW_WRITE, 9'h1FF, 16'hA5A5, 16'h0000, 1'b0};
    vecs[4] = '{TW_RW_READ,  9'h100, 16'h0000, 16'h00FF, 1'b0};

    in_rst = 1'b1;
    in_cmd_valid = 1'b0; in_cmd_r_w = 1'b0; in_cmd_addr = '0; in_cmd_wr_data = '0;
    in_rsp_ready = 1'b1;
    repeat (3) @(posedge in_clk);
    #1;
    check_reset_outputs("rst0");
    in_rst = 1'b0;
    align();

    // Enqueue into an empty idle block: start appears two edges later
    in_cmd_valid = 1'b1; in_cmd_r_w = TW_RW_WRITE; in_cmd_addr = 9'h0F0; in_cmd_wr_data = 16'h00AA;
    q_tw.push_back('{TW_RW_WRITE, 9'h0F0, 16'h00AA});
    q_rsp.push_back('{16'h0000, 1'b0});
    @(posedge in_clk); #1; in_cmd_valid = 1'b0;
    check("lat_e0", 32'(out_tw_start), 32'(0));
    @(posedge in_clk); #1;
    check("lat_e1", 32'(out_tw_start), 32'(0));
    @(posedge in_clk); #1;
    check("lat_e2", 32'(out_tw_start), 32'(1));
    drain("lat_drain", 300);

    // Table of single commands
    for (int i = 0; i < 5; i++) begin
      align();
      send(vecs[i].rw, vecs[i].addr, vecs[i].wdata, 1'b1, vecs[i].exp_data, vecs[i].exp_to);
      drain("vec_drain", 300);
    end

    // Five back-to-back commands with a slow master
    m_delay = 30; m_busy_len = 10;
    align();
    send(TW_RW_WRITE, 9'h010, 16'h1111, 1'b1, 16'h0000, 1'b0);
    send(TW_RW_READ,  9'h011, 16'h0000, 1'b1, 16'h11EE, 1'b0);
    send(TW_RW_WRITE, 9'h012, 16'h3333, 1'b1, 16'h0000, 1'b0);
    send(TW_RW_READ,  9'h013, 16'h0000, 1'b1, 16'h13EC, 1'b0);
    send(TW_RW_READ,  9'h1A5, 16'h0000, 1'b1, 16'hBEEF, 1'b0);
    check("full_level", 32'(out_fifo_level), 32'(4));
    check("full_ready", 32'(out_cmd_ready),  32'(0));
    drain("full_drain", 1500);

    // Master never raises busy: timeout response, then the next command runs
    m_delay = 5; m_busy_len = 40;
    m_never = 1'b1;
    align();
    send(TW_RW_READ, 9'h055, 16'h0000, 1'b0, 16'h0000, 1'b1);
    cnt = 0; n = 0;
    while (!out_rsp_valid && n < 300) begin
      @(negedge in_clk);
      if (out_tw_start) cnt++;
      n++;
    end
    check("to_rsp_seen", 32'(out_rsp_valid), 32'(1));
    check("to_start_low", 32'(out_tw_start), 32'(0));
    check("to_start_cycles", 32'(cnt >= int'(TO) && cnt <= int'(TO) + 1), 32'(1));
    m_never = 1'b0;
    align();
    send(TW_RW_WRITE, 9'h0AA, 16'h5555, 1'b1, 16'h0000, 1'b0);
    drain("to_drain", 400);

    // Response back-pressure: data held, queue keeps accepting
    in_rsp_ready = 1'b0;
    align();
    send(TW_RW_READ, 9'h042, 16'h0000, 1'b1, 16'h42BD, 1'b0);
    n = 0;
    while (!out_rsp_valid && n < 200) begin
      @(negedge in_clk);
      n++;
    end
    check("bp_valid", 32'(out_rsp_valid), 32'(1));
    align();
    send(TW_RW_WRITE, 9'h011, 16'h0F0F, 1'b1, 16'h0000, 1'b0);
    send(TW_RW_READ,  9'h1A5, 16'h0000, 1'b1, 16'hBEEF, 1'b0);
    check("bp_level", 32'(out_fifo_level), 32'(2));
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge in_clk);
      if (!out_rsp_valid || out_rsp_data !== 16'h42BD || out_rsp_timeout) ok = 1'b0;
    end
    check("bp_stable", 32'(ok), 32'(1));
    align();
    in_rsp_ready = 1'b1;
    drain("bp_drain", 600);

    // Reset while the master is busy with two commands queued
    m_delay = 2; m_busy_len = 40;
    align();
    send(TW_RW_WRITE, 9'h1C3, 16'h7777, 1'b1, 16'h0000, 1'b0);
    send(TW_RW_READ,  9'h042, 16'h0000, 1'b1, 16'h42BD, 1'b0);
    send(TW_RW_WRITE, 9'h011, 16'h2222, 1'b1, 16'h0000, 1'b0);
    n = 0;
    while (!in_tw_busy && n < 100) begin
      @(negedge in_clk);
      n++;
    end
    repeat (3) @(negedge in_clk);
    check("mid_level", 32'(out_fifo_level), 32'(2));
    check("mid_start", 32'(out_tw_start),   32'(0));
    n_save = n_rsp;
    align();
    m_abort = 1'b1;
    in_rst  = 1'b1;
    #1;
    check_reset_outputs("rst1");
    q_tw.delete();
    q_rsp.delete();
    repeat (3) @(posedge in_clk);
    #1;
    in_rst  = 1'b0;
    m_abort = 1'b0;
    repeat (60) @(negedge in_clk);
    check("rst1_no_rsp", 32'(n_rsp - n_save), 32'(0));
    check("rst1_idle",   32'(out_idle),       32'(1));

    // Block recovers after reset
    m_delay = 5;
    align();
    send(TW_RW_READ, 9'h100, 16'h0000, 1'b1, 16'h00FF, 1'b0);
    drain("post_drain", 300);
    check("tw_leftover", 32'(q_tw.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
